// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl
// Description : Gate front-end. Synchronises and debounces the enter/exit
//               push-buttons, validates each request against the slot-select
//               switches and the tracker's occupancy flags, then issues one
//               enter/exit strobe plus a timed gate-open window, or a reject
//               pulse with a reason code.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int GATE_OPEN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       btn_exit,
  input  logic [2:0] sw_sel,
  input  logic       car1_state,
  input  logic       car2_state,
  input  logic       car3_state,
  output logic       car_enter,
  output logic       car_exit,
  output logic [2:0] car_sel,
  output logic       gate_open,
  output logic       busy,
  output logic       reject,
  output logic [1:0] reject_code
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW   = $clog2(GATE_OPEN_CYCLES + 1);

  localparam logic [1:0] C_CODE_NONE = 2'd0;
  localparam logic [1:0] C_CODE_SEL  = 2'd1;
  localparam logic [1:0] C_CODE_OCC  = 2'd2;
  localparam logic [1:0] C_CODE_BOTH = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_STROBE  = 3'd2,
    S_GATE    = 3'd3,
    S_REJECT  = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // bit 0 = enter, bit 1 = exit
  logic [1:0] btn_raw;
  logic [1:0] db_level;
  logic [1:0] db_prev_q;
  logic [1:0] rise;

  assign btn_raw = {btn_exit, btn_enter};

  // Per-button synchroniser and debounce filter
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;
    logic            db_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Count consecutive cycles the synchronised level disagrees with the
    // accepted level; any agreement (bounce) restarts the count.
    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d = ~db_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    // Synchroniser and debounce registers
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
      end
    end

    assign db_level[i] = db_q;
  end

  assign rise = db_level & ~db_prev_q;

  state_t         state_q, state_d;
  logic           req_enter_q, req_enter_d;
  logic           req_exit_q, req_exit_d;
  logic           car_enter_q, car_enter_d;
  logic           car_exit_q, car_exit_d;
  logic [2:0]     car_sel_q, car_sel_d;
  logic           gate_open_q, gate_open_d;
  logic           busy_q, busy_d;
  logic           reject_q, reject_d;
  logic [1:0]     reject_code_q, reject_code_d;
  logic [GW-1:0]  gate_cnt_q, gate_cnt_d;

  logic sel_onehot;
  logic slot_occupied;
  logic occ_conflict;

  assign sel_onehot    = (sw_sel != 3'b000) && ((sw_sel & (sw_sel - 3'd1)) == 3'b000);
  assign slot_occupied = |(sw_sel & {car3_state, car2_state, car1_state});
  assign occ_conflict  = (req_enter_q && slot_occupied) || (req_exit_q && !slot_occupied);

  // Next-state and registered-output logic of the transaction FSM
  always_comb begin
    state_d       = state_q;
    req_enter_d   = req_enter_q;
    req_exit_d    = req_exit_q;
    car_enter_d   = 1'b0;
    car_exit_d    = 1'b0;
    car_sel_d     = car_sel_q;
    gate_open_d   = 1'b0;
    reject_d      = 1'b0;
    reject_code_d = reject_code_q;
    gate_cnt_d    = gate_cnt_q;

    case (state_q)
      S_IDLE: begin
        car_sel_d = 3'b000;
        if (|rise) begin
          req_enter_d = rise[0];
          req_exit_d  = rise[1];
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (req_enter_q && req_exit_q) begin
          reject_code_d = C_CODE_BOTH;
          reject_d      = 1'b1;
          state_d       = S_REJECT;
        end else if (!sel_onehot) begin
          reject_code_d = C_CODE_SEL;
          reject_d      = 1'b1;
          state_d       = S_REJECT;
        end else if (occ_conflict) begin
          reject_code_d = C_CODE_OCC;
          reject_d      = 1'b1;
          state_d       = S_REJECT;
        end else begin
          reject_code_d = C_CODE_NONE;
          car_sel_d     = sw_sel;
          car_enter_d   = req_enter_q;
          car_exit_d    = req_exit_q;
          state_d       = S_STROBE;
        end
      end
      S_STROBE: begin
        // gate_open is registered, so the count covers the cycles after this
        gate_open_d = 1'b1;
        gate_cnt_d  = GW'(GATE_OPEN_CYCLES - 1);
        state_d     = S_GATE;
      end
      S_GATE: begin
        if (gate_cnt_q == '0) begin
          car_sel_d = 3'b000;
          state_d   = S_RELEASE;
        end else begin
          gate_open_d = 1'b1;
          gate_cnt_d  = gate_cnt_q - GW'(1);
        end
      end
      S_REJECT: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Holding a button must never retrigger: wait for both to drop
        if (db_level == 2'b00) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        car_sel_d = 3'b000;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_enter_q   <= 1'b0;
      req_exit_q    <= 1'b0;
      car_enter_q   <= 1'b0;
      car_exit_q    <= 1'b0;
      car_sel_q     <= 3'b000;
      gate_open_q   <= 1'b0;
      busy_q        <= 1'b0;
      reject_q      <= 1'b0;
      reject_code_q <= 2'b00;
      gate_cnt_q    <= '0;
      db_prev_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      req_enter_q   <= req_enter_d;
      req_exit_q    <= req_exit_d;
      car_enter_q   <= car_enter_d;
      car_exit_q    <= car_exit_d;
      car_sel_q     <= car_sel_d;
      gate_open_q   <= gate_open_d;
      busy_q        <= busy_d;
      reject_q      <= reject_d;
      reject_code_q <= reject_code_d;
      gate_cnt_q    <= gate_cnt_d;
      db_prev_q     <= db_level;
    end
  end

  assign car_enter   = car_enter_q;
  assign car_exit    = car_exit_q;
  assign car_sel     = car_sel_q;
  assign gate_open   = gate_open_q;
  assign busy        = busy_q;
  assign reject      = reject_q;
  assign reject_code = reject_code_q;

endmodule
`default_nettype wire

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Front-end gate controller that turns raw driver push-buttons and the slot-select switches into the single-cycle `car_enter` / `car_exit` strobes and the `car_sel` one-hot bus consumed by `car_enter_exit`. It synchronises and debounces the buttons and validates each request against the current occupancy flags (`car1_state`..`car3_state`) fed back from `car_enter_exit`. It issues at most one transaction per press and holds the physical gate open for a fixed time. It sits between the board I/O and the car tracker; `timer_count` and cost logic are untouched.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised cycles required before a button level change is accepted (≥1).
- `GATE_OPEN_CYCLES`, 8: cycles `gate_open` stays high per accepted transaction (≥1).
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `btn_enter` in 1: raw enter button, asynchronous, active-high.
- `btn_exit` in 1: raw exit button, asynchronous, active-high.
- `sw_sel` in 3: slot-select switches, quasi-static; sampled in CHECK.
- `car1_state`, `car2_state`, `car3_state` in 1 each: occupancy from tracker (1 = parked).
- `car_enter` out 1: one-cycle enter strobe.
- `car_exit` out 1: one-cycle exit strobe.
- `car_sel` out 3: latched one-hot slot; valid during STROBE and GATE, 3'b000 otherwise.
- `gate_open` out 1: gate actuator drive.
- `busy` out 1: high in every state except IDLE.
- `reject` out 1: one-cycle pulse on a refused request.
- `reject_code` out 2: reason, held until next request is evaluated. 0 = none, 1 = bad select, 2 = occupancy conflict, 3 = both buttons.

## Operation
- Per button: 2-flop synchroniser, then a debounce counter. The debounced level flips only after the synchronised level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- Request = rising edge of a debounced level while in IDLE. Edges in any other state are ignored.
- FSM states: IDLE, CHECK, STROBE, GATE, REJECT, RELEASE.
- IDLE→CHECK on a request; the request type (enter/exit/both) is latched.
- CHECK validates one cycle, in priority order:
  - Both buttons rose in the same cycle: code 3.
  - `sw_sel` not exactly one-hot: code 1.
  - Enter on an occupied slot, or exit on an empty slot: code 2.
  - Otherwise valid: latch `sw_sel`, set `reject_code`=0, go to STROBE.
- On any refusal: go to REJECT.
- STROBE: assert `car_enter` or `car_exit` for exactly 1 cycle, with `car_sel` driven; then go to GATE.
- GATE: `gate_open`=1 for exactly `GATE_OPEN_CYCLES` cycles (down-counter, width $clog2(GATE_OPEN_CYCLES+1)); `car_sel` is held. Then go to RELEASE.
- REJECT: `reject`=1 for 1 cycle, then go to RELEASE.
- RELEASE: wait until both debounced levels are 0, then go to IDLE. A held button therefore never retriggers.
- `car_enter` and `car_exit` are never high in the same cycle. A strobe is never issued while a previous transaction is in flight.
- Occupancy inputs are sampled only in CHECK. Their change during GATE (tracker update) is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (`car_sel`=000, `reject_code`=00); synchronisers, debounced levels and counters 0.
- A button held through reset release is seen as a new press once debounced. This is accepted behaviour.
- Latency: let edge 0 be the first edge sampling the button high, with the button stable afterwards.
  - Debounced level rises at edge 1+D, where D = `DEBOUNCE_CYCLES`.
  - CHECK is entered at edge 2+D.
  - STROBE is entered at edge 3+D; the strobe is high in the cycle after edge 3+D (D=4: edge 7).
  - `gate_open` is high during the next `GATE_OPEN_CYCLES` cycles.
  - `reject` follows the same timing as the strobe.
- Minimum spacing between strobes: 3 + `GATE_OPEN_CYCLES` + release + D + 3 cycles.
- Reset mid-transaction (any state): next cycle everything is at reset values. Any strobe or `gate_open` is cut off; no partial strobe is re-issued.
- `sw_sel` changing after CHECK has no effect on `car_sel`.

## Test plan
- Reset, all occupancy 0, `sw_sel`=001, clean 20-cycle enter press → `car_enter` one cycle at edge 7, `car_sel`=001 for 9 cycles, `gate_open` 8 cycles, `busy` falls after release; `car_exit` never high.
- `car2_state`=1, `sw_sel`=010, exit press → `car_exit` one cycle with `car_sel`=010. Repeat as an enter press → `reject` pulse, `reject_code`=2, no strobe, no `gate_open`.
- `sw_sel`=011 enter press → `reject`, code 1. `sw_sel`=000 → code 1.
- Both buttons rising together → code 3, no strobe. Bounce pattern 1,0,1,1,0,1 then stable 1 → exactly one strobe, at D+3 edges after the last transition-to-1 sample.
- Button held 100 cycles → exactly one strobe. A second press during GATE → ignored; a press after RELEASE → new transaction.
- `reset` asserted 3 cycles into GATE → `gate_open`, `car_sel`, `busy` all 0 the next cycle; no strobe follows after release unless the button is still held.
